vector_bitwise_sequencer: RTL and testbench

Sequencer that executes one vector bitwise/min-max instruction over a full vector register by streaming it through a shared combinational bitwise datapath, one BEAT_W-bit beat per cycle. It accepts a command through a valid/ready handshake and issues register-file reads. It drives the datapath operands and writes each result beat back with tail byte-enables derived from vl. It sits between vector issue and the vector register file.

---
 rtl/vector_bitwise_sequencer_if.sv | 68 ++++++
 rtl/vector_bitwise_sequencer.sv | 204 ++++++++++++++++++++
 tb/tb_vector_bitwise_sequencer.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/vector_bitwise_sequencer_if.sv
// Bus between the bitwise sequencer and its environment: command issue,
// register-file read/write ports and the shared bitwise datapath.
// master = environment side, slave = sequencer side.
interface vector_bitwise_sequencer_if #(
   parameter int VLEN   = 4096,
   parameter int ELEN   = 32,
   parameter int BEAT_W = 256
);
   localparam int NUM_BEATS = VLEN / BEAT_W;
   localparam int VL_W      = $clog2(VLEN / 8) + 1;
   localparam int BI_W      = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
   localparam int BE_W      = BEAT_W / 8;

   // command issue
   logic              cmd_valid;
   logic              cmd_ready;
   logic [4:0]        cmd_op;
   logic [1:0]        cmd_sew;
   logic [VL_W-1:0]   cmd_vl;
   logic [4:0]        cmd_vs1;
   logic [4:0]        cmd_vs2;
   logic [4:0]        cmd_vd;
   logic              cmd_use_scalar;
   logic [ELEN-1:0]   cmd_scalar;
   logic              stall;

   // register-file read port
   logic              rf_rd_en;
   logic [4:0]        rf_rd_addr1;
   logic [4:0]        rf_rd_addr2;
   logic [BI_W-1:0]   rf_rd_beat;
   logic [BEAT_W-1:0] rf_rd_data1;
   logic [BEAT_W-1:0] rf_rd_data2;

   // shared datapath
   logic [BEAT_W-1:0] dp_a;
   logic [BEAT_W-1:0] dp_b;
   logic [4:0]        dp_op;
   logic [1:0]        dp_sew;
   logic [BEAT_W-1:0] dp_result;

   // register-file write port
   logic              rf_wr_en;
   logic [4:0]        rf_wr_addr;
   logic [BI_W-1:0]   rf_wr_beat;
   logic [BEAT_W-1:0] rf_wr_data;
   logic [BE_W-1:0]   rf_wr_be;

   // status
   logic              busy;
   logic              done;

   modport master (
      output cmd_valid, cmd_op, cmd_sew, cmd_vl, cmd_vs1, cmd_vs2, cmd_vd,
             cmd_use_scalar, cmd_scalar, stall, rf_rd_data1, rf_rd_data2, dp_result,
      input  cmd_ready, rf_rd_en, rf_rd_addr1, rf_rd_addr2, rf_rd_beat,
             dp_a, dp_b, dp_op, dp_sew, rf_wr_en, rf_wr_addr, rf_wr_beat,
             rf_wr_data, rf_wr_be, busy, done
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_sew, cmd_vl, cmd_vs1, cmd_vs2, cmd_vd,
             cmd_use_scalar, cmd_scalar, stall, rf_rd_data1, rf_rd_data2, dp_result,
      output cmd_ready, rf_rd_en, rf_rd_addr1, rf_rd_addr2, rf_rd_beat,
             dp_a, dp_b, dp_op, dp_sew, rf_wr_en, rf_wr_addr, rf_wr_beat,
             rf_wr_data, rf_wr_be, busy, done
   );
endinterface

// File: rtl/vector_bitwise_sequencer.sv
// Streams one vector bitwise/min-max instruction through the shared
// datapath a beat per cycle: read both sources, feed the datapath one cycle
// later, write the result back with tail byte-enables derived from vl.

// One byte lane of a beat: scalar-splat byte select and tail byte-enable.
module vbs_byte_lane #(
   parameter int LANE = 0,
   parameter int BE_W = 32,
   parameter int BI_W = 4,
   parameter int VL_W = 10
) (
   input  logic [1:0]      sew,
   input  logic [63:0]     scalar64,
   input  logic [BI_W-1:0] beat,
   input  logic [VL_W-1:0] vl_bytes,
   output logic [7:0]      splat_byte,
   output logic            be
);
   localparam logic [2:0] POS = 3'(LANE % 8);

   logic [2:0] sel;

   // byte within the element this lane falls in, and whether it is live
   always_comb begin
      sel = '0;
      unique case (sew)
         2'd0:    sel = 3'd0;
         2'd1:    sel = {2'b00, POS[0]};
         2'd2:    sel = {1'b0, POS[1:0]};
         default: sel = POS;
      endcase
      splat_byte = scalar64[{sel, 3'b000} +: 8];
      be = (int'(beat) * BE_W + LANE) < int'(vl_bytes);
   end
endmodule

module vector_bitwise_sequencer #(
   parameter int VLEN   = 4096,
   parameter int ELEN   = 32,
   parameter int BEAT_W = 256
) (
   input  logic                           clk,
   input  logic                           reset,
   vector_bitwise_sequencer_if.slave      bus
);
   localparam int NUM_BEATS = VLEN / BEAT_W;
   localparam int VL_W      = $clog2(VLEN / 8) + 1;
   localparam int BI_W      = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
   localparam int BE_W      = BEAT_W / 8;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

   state_t            state_q, state_d;
   logic [BI_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [BI_W-1:0]   last_beat_q, last_beat_d;
   logic              wr_vld_q, wr_vld_d;
   logic [BI_W-1:0]   wr_beat_q, wr_beat_d;
   logic [4:0]        op_q, op_d;
   logic [1:0]        sew_q, sew_d;
   logic [4:0]        vs1_q, vs1_d;
   logic [4:0]        vs2_q, vs2_d;
   logic [4:0]        vd_q, vd_d;
   logic [ELEN-1:0]   scalar_q, scalar_d;
   logic              use_scalar_q, use_scalar_d;
   // vl kept as a byte count: the tail test becomes a plain byte compare
   logic [VL_W-1:0]   vl_bytes_q, vl_bytes_d;

   logic              rd_en;
   logic [VL_W-1:0]   vl_max, vl_eff, vl_bytes_new;
   int                n_beats_new;

   // size the incoming command: clamp vl to one register, count beats
   always_comb begin
      vl_max       = VL_W'((VLEN / 8) >> bus.cmd_sew);
      vl_eff       = (bus.cmd_vl < vl_max) ? bus.cmd_vl : vl_max;
      vl_bytes_new = VL_W'(32'(vl_eff) << bus.cmd_sew);
      n_beats_new  = (int'(vl_bytes_new) + BE_W - 1) / BE_W;
   end

   // sequencing FSM: next state, read issue and command latching
   always_comb begin
      state_d      = state_q;
      rd_ptr_d     = rd_ptr_q;
      last_beat_d  = last_beat_q;
      op_d         = op_q;
      sew_d        = sew_q;
      vs1_d        = vs1_q;
      vs2_d        = vs2_q;
      vd_d         = vd_q;
      scalar_d     = scalar_q;
      use_scalar_d = use_scalar_q;
      vl_bytes_d   = vl_bytes_q;
      rd_en        = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (bus.cmd_valid) begin
               op_d         = bus.cmd_op;
               sew_d        = bus.cmd_sew;
               vs1_d        = bus.cmd_vs1;
               vs2_d        = bus.cmd_vs2;
               vd_d         = bus.cmd_vd;
               scalar_d     = bus.cmd_scalar;
               use_scalar_d = bus.cmd_use_scalar;
               vl_bytes_d   = vl_bytes_new;
               rd_ptr_d     = '0;
               last_beat_d  = BI_W'(n_beats_new - 1);
               state_d      = (n_beats_new == 0) ? S_DONE : S_RUN;
            end
         end
         S_RUN: begin
            if (!bus.stall) begin
               rd_en = 1'b1;
               if (rd_ptr_q == last_beat_q) state_d = S_DRAIN;
               else rd_ptr_d = rd_ptr_q + BI_W'(1);
            end
         end
         // last read's write happens here via the write stage
         S_DRAIN: state_d = S_DONE;
         default: state_d = S_IDLE;
      endcase
   end

   // write stage is a one-cycle delayed copy of the read issue
   always_comb begin
      wr_vld_d  = rd_en;
      wr_beat_d = rd_ptr_q;
   end

   // state and command registers; reset drops any in-flight command
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= S_IDLE;
         rd_ptr_q     <= '0;
         last_beat_q  <= '0;
         wr_vld_q     <= 1'b0;
         wr_beat_q    <= '0;
         op_q         <= '0;
         sew_q        <= '0;
         vs1_q        <= '0;
         vs2_q        <= '0;
         vd_q         <= '0;
         scalar_q     <= '0;
         use_scalar_q <= 1'b0;
         vl_bytes_q   <= '0;
      end else begin
         state_q      <= state_d;
         rd_ptr_q     <= rd_ptr_d;
         last_beat_q  <= last_beat_d;
         wr_vld_q     <= wr_vld_d;
         wr_beat_q    <= wr_beat_d;
         op_q         <= op_d;
         sew_q        <= sew_d;
         vs1_q        <= vs1_d;
         vs2_q        <= vs2_d;
         vd_q         <= vd_d;
         scalar_q     <= scalar_d;
         use_scalar_q <= use_scalar_d;
         vl_bytes_q   <= vl_bytes_d;
      end
   end

   // 64-bit sign extension only shows through when SEW=64
   logic [63:0]           scalar64;
   logic [BE_W-1:0][7:0]  splat;
   logic [BE_W-1:0]       be_lane;

   assign scalar64 = 64'($signed(scalar_q));

   for (genvar g = 0; g < BE_W; g++) begin : g_lane
      vbs_byte_lane #(.LANE(g), .BE_W(BE_W), .BI_W(BI_W), .VL_W(VL_W)) u_lane (
         .sew        (sew_q),
         .scalar64   (scalar64),
         .beat       (wr_beat_q),
         .vl_bytes   (vl_bytes_q),
         .splat_byte (splat[g]),
         .be         (be_lane[g])
      );
   end

   // datapath operands only live during the write stage
   always_comb begin
      bus.dp_a = '0;
      bus.dp_b = '0;
      if (wr_vld_q) begin
         bus.dp_a = use_scalar_q ? splat : bus.rf_rd_data1;
         bus.dp_b = bus.rf_rd_data2;
      end
   end

   assign bus.cmd_ready   = (state_q == S_IDLE);
   assign bus.busy        = (state_q != S_IDLE);
   assign bus.done        = (state_q == S_DONE);
   assign bus.rf_rd_en    = rd_en;
   assign bus.rf_rd_addr1 = vs1_q;
   assign bus.rf_rd_addr2 = vs2_q;
   assign bus.rf_rd_beat  = rd_ptr_q;
   assign bus.dp_op       = op_q;
   assign bus.dp_sew      = sew_q;
   assign bus.rf_wr_en    = wr_vld_q;
   assign bus.rf_wr_addr  = vd_q;
   assign bus.rf_wr_beat  = wr_beat_q;
   assign bus.rf_wr_data  = wr_vld_q ? bus.dp_result : '0;
   assign bus.rf_wr_be    = wr_vld_q ? be_lane : '0;
endmodule

// File: tb/tb_vector_bitwise_sequencer.sv
// Scoreboard bench for vector_bitwise_sequencer: expected writes are queued
// when a command is driven and compared as the write port produces them.
module tb_vector_bitwise_sequencer;
   localparam int VLEN   = 4096;
   localparam int ELEN   = 32;
   localparam int BEAT_W = 256;
   localparam int BE_W   = BEAT_W / 8;
   localparam int VL_W   = $clog2(VLEN / 8) + 1;
   localparam logic [4:0] OP_AND = 5'd0, OP_OR = 5'd1, OP_XOR = 5'd2, OP_MAX = 5'd7;

   typedef struct {
      int               beat;
      logic [BE_W-1:0]  be;
      logic [BEAT_W-1:0] a;
      logic [BEAT_W-1:0] b;
      logic [4:0]       op;
      logic [4:0]       vd;
      logic [1:0]       sew;
   } wr_exp_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int checks = 0;
   int errors = 0;
   wr_exp_t sb[$];
   wr_exp_t e;

   vector_bitwise_sequencer_if #(.VLEN(VLEN), .ELEN(ELEN), .BEAT_W(BEAT_W)) bus ();

   vector_bitwise_sequencer #(.VLEN(VLEN), .ELEN(ELEN), .BEAT_W(BEAT_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [BEAT_W-1:0] got, input logic [BEAT_W-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [BEAT_W-1:0] rf_word(input logic [4:0] r, input int k);
      logic [BEAT_W-1:0] w;
      for (int i = 0; i < BEAT_W / 32; i++)
         w[32*i +: 32] = 32'((int'(r) * 64 + k * 8 + i + 1) * 32'h9E3779B9);
      return w;
   endfunction

   function automatic logic [BEAT_W-1:0] splat(input logic [31:0] s, input logic [1:0] sew);
      case (sew)
         2'd0:    return {32{s[7:0]}};
         2'd1:    return {16{s[15:0]}};
         2'd2:    return {8{s}};
         default: return {4{{32{s[31]}}, s}};
      endcase
   endfunction

   // stand-in datapath: any fixed function of a, b and op will do
   function automatic logic [BEAT_W-1:0] dp_model(input logic [BEAT_W-1:0] a, input logic [BEAT_W-1:0] b,
                                                  input logic [4:0] op);
      return a ^ {b[BEAT_W-2:0], b[BEAT_W-1]} ^ {32{3'b000, op}};
   endfunction

   assign bus.dp_result = dp_model(bus.dp_a, bus.dp_b, bus.dp_op);

   // register file: data one cycle after the read request
   always @(posedge clk) begin
      if (bus.rf_rd_en) begin
         bus.rf_rd_data1 <= rf_word(bus.rf_rd_addr1, int'(bus.rf_rd_beat));
         bus.rf_rd_data2 <= rf_word(bus.rf_rd_addr2, int'(bus.rf_rd_beat));
      end
   end

   // write-port monitor against the scoreboard
   always @(negedge clk) begin
      if (bus.rf_wr_en) begin
         if (sb.size() == 0) begin
            chk("wr_unexpected", BEAT_W'(bus.rf_wr_en), BEAT_W'(0));
         end else begin
            e = sb.pop_front();
            chk("wr_beat", BEAT_W'(bus.rf_wr_beat), BEAT_W'(e.beat));
            chk("wr_be",   BEAT_W'(bus.rf_wr_be),   BEAT_W'(e.be));
            chk("wr_addr", BEAT_W'(bus.rf_wr_addr), BEAT_W'(e.vd));
            chk("dp_op",   BEAT_W'(bus.dp_op),      BEAT_W'(e.op));
            chk("dp_sew",  BEAT_W'(bus.dp_sew),     BEAT_W'(e.sew));
            chk("dp_a",    bus.dp_a,                e.a);
            chk("dp_b",    bus.dp_b,                e.b);
            chk("wr_data", bus.rf_wr_data,          dp_model(e.a, e.b, e.op));
         end
      end
   end

   task automatic drive_cmd(input logic [4:0] op, input logic [1:0] sew, input int vl,
                            input logic [4:0] vs1, input logic [4:0] vs2, input logic [4:0] vd,
                            input logic use_sc, input logic [31:0] sc, output int n);
      int s_bits;
      int vl_eff;
      wr_exp_t x;
      s_bits = 8 << sew;
      vl_eff = (vl < VLEN / s_bits) ? vl : VLEN / s_bits;
      n = (vl_eff * s_bits + BEAT_W - 1) / BEAT_W;
      @(negedge clk);
      bus.cmd_op = op; bus.cmd_sew = sew; bus.cmd_vl = VL_W'(vl);
      bus.cmd_vs1 = vs1; bus.cmd_vs2 = vs2; bus.cmd_vd = vd;
      bus.cmd_use_scalar = use_sc; bus.cmd_scalar = sc;
      bus.cmd_valid = 1'b1;
      chk("ready_idle", BEAT_W'(bus.cmd_ready), BEAT_W'(1));
      for (int k = 0; k < n; k++) begin
         x.beat = k;
         x.a    = use_sc ? splat(sc, sew) : rf_word(vs1, k);
         x.b    = rf_word(vs2, k);
         x.op   = op;
         x.vd   = vd;
         x.sew  = sew;
         for (int j = 0; j < BE_W; j++)
            x.be[j] = ((k * BEAT_W + 8 * j) / s_bits) < vl_eff;
         sb.push_back(x);
      end
      @(posedge clk);
      #1 bus.cmd_valid = 1'b0;
   endtask

   // one command end to end; cycle 1 is the cycle after the accept edge
   task automatic run_cmd(input logic [4:0] op, input logic [1:0] sew, input int vl,
                          input logic [4:0] vs1, input logic [4:0] vs2, input logic [4:0] vd,
                          input logic use_sc, input logic [31:0] sc,
                          input int st_lo, input int st_hi, input int exp_done);
      int n, rd_cnt, busy_cnt, done_cyc;
      logic prev_rd;
      drive_cmd(op, sew, vl, vs1, vs2, vd, use_sc, sc, n);
      rd_cnt = 0; busy_cnt = 0; done_cyc = -1; prev_rd = 1'b0;
      for (int c = 1; c <= 60; c++) begin
         bus.stall = (c >= st_lo) && (c <= st_hi);
         @(negedge clk);
         if (bus.busy) busy_cnt++;
         if (bus.stall) chk("stall_rd", BEAT_W'(bus.rf_rd_en), BEAT_W'(0));
         chk("wr_after_rd", BEAT_W'(bus.rf_wr_en), BEAT_W'(prev_rd));
         if (bus.rf_rd_en) begin
            chk("rd_beat", BEAT_W'(bus.rf_rd_beat), BEAT_W'(rd_cnt));
            chk("rd_addr", BEAT_W'({bus.rf_rd_addr1, bus.rf_rd_addr2}), BEAT_W'({vs1, vs2}));
            rd_cnt++;
         end
         prev_rd = bus.rf_rd_en;
         if (bus.done) begin
            done_cyc = c;
            @(posedge clk);
            #1;
            chk("ready_after", BEAT_W'(bus.cmd_ready), BEAT_W'(1));
            chk("done_pulse",  BEAT_W'(bus.done),      BEAT_W'(0));
            break;
         end
         @(posedge clk);
         #1;
      end
      bus.stall = 1'b0;
      chk("done_cycle", BEAT_W'(done_cyc), BEAT_W'(exp_done));
      chk("rd_count",   BEAT_W'(rd_cnt),   BEAT_W'(n));
      chk("busy_cyc",   BEAT_W'(busy_cnt), BEAT_W'(exp_done));
      chk("sb_drained", BEAT_W'(sb.size()), BEAT_W'(0));
      sb.delete();
   endtask

   initial begin
      int n;
      bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_sew = '0; bus.cmd_vl = '0;
      bus.cmd_vs1 = '0; bus.cmd_vs2 = '0; bus.cmd_vd = '0;
      bus.cmd_use_scalar = 1'b0; bus.cmd_scalar = '0; bus.stall = 1'b0;

      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_ready", BEAT_W'(bus.cmd_ready), BEAT_W'(1));
      chk("rst_busy",  BEAT_W'(bus.busy),      BEAT_W'(0));
      chk("rst_rd_en", BEAT_W'(bus.rf_rd_en),  BEAT_W'(0));
      chk("rst_wr_en", BEAT_W'(bus.rf_wr_en),  BEAT_W'(0));
      chk("rst_done",  BEAT_W'(bus.done),      BEAT_W'(0));
      chk("rst_wr_be", BEAT_W'(bus.rf_wr_be),  BEAT_W'(0));
      reset = 1'b0;

      // full register, SEW=32
      run_cmd(OP_AND, 2'd2, 128, 5'd1, 5'd2, 5'd3, 1'b0, 32'h0, 0, 0, 18);
      // short vl: one beat, ten bytes live
      run_cmd(OP_OR, 2'd0, 10, 5'd4, 5'd5, 5'd6, 1'b0, 32'h0, 0, 0, 3);
      // vl=0 goes straight to DONE
      run_cmd(OP_XOR, 2'd1, 0, 5'd7, 5'd8, 5'd9, 1'b0, 32'h0, 0, 0, 1);
      // scalar splat, SEW=16, lanes of 0x8000
      run_cmd(OP_MAX, 2'd1, 16, 5'd10, 5'd11, 5'd12, 1'b1, 32'hFFFF8000, 0, 0, 3);
      // largest encodable vl clamps to 512 bytes; stall cycles 4-6 delays done by 3
      run_cmd(OP_OR, 2'd0, 1023, 5'd13, 5'd14, 5'd15, 1'b0, 32'h0, 4, 6, 21);
      // SEW=64 sign-extended splat, partial second beat
      run_cmd(OP_MAX, 2'd3, 7, 5'd16, 5'd17, 5'd18, 1'b1, 32'h80000001, 0, 0, 4);

      // asynchronous reset in cycle 5 of a 16-beat command
      drive_cmd(OP_AND, 2'd2, 128, 5'd1, 5'd2, 5'd3, 1'b0, 32'h0, n);
      repeat (4) @(posedge clk);
      #3 reset = 1'b1;
      #1;
      chk("arst_ready",   BEAT_W'(bus.cmd_ready),  BEAT_W'(1));
      chk("arst_busy",    BEAT_W'(bus.busy),       BEAT_W'(0));
      chk("arst_rd_en",   BEAT_W'(bus.rf_rd_en),   BEAT_W'(0));
      chk("arst_wr_en",   BEAT_W'(bus.rf_wr_en),   BEAT_W'(0));
      chk("arst_rd_beat", BEAT_W'(bus.rf_rd_beat), BEAT_W'(0));
      chk("arst_dp_a",    bus.dp_a,                BEAT_W'(0));
      sb.delete();
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("post_rst_ready", BEAT_W'(bus.cmd_ready), BEAT_W'(1));

      // normal command after reset, tail of 4 bytes on beat 4
      run_cmd(OP_AND, 2'd2, 33, 5'd20, 5'd21, 5'd22, 1'b0, 32'h0, 0, 0, 7);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
